// File: rtl/fir_pe_fold_ctrl_if.sv
// -----------------------------------------------------------------------------
// fir_pe_fold_ctrl_if
//   Sample-in / result-out streaming bundle for the folded FIR sequencer.
//   x_*  : one input sample per valid/ready transfer (source -> controller)
//   y_*  : one filtered result per valid/ready transfer (controller -> sink)
//   Modports:
//     master : the side that offers samples and consumes results
//     slave  : the controller side
// -----------------------------------------------------------------------------
interface fir_pe_fold_ctrl_if #(
    parameter int XW = 8,
    parameter int YW = 16
);
    logic          x_valid;
    logic          x_ready;
    logic [XW-1:0] x_data;
    logic          y_valid;
    logic          y_ready;
    logic [YW-1:0] y_data;

    modport master (
        output x_valid, x_data, y_ready,
        input  x_ready, y_valid, y_data
    );

    modport slave (
        input  x_valid, x_data, y_ready,
        output x_ready, y_valid, y_data
    );
endinterface

// File: rtl/fir_pe_fold_ctrl.sv
// -----------------------------------------------------------------------------
// fir_pe_fold_ctrl
//   Folded-FIR sequencer. One external fir_pe is time-shared across TAPS taps:
//   each accepted sample is shifted into a delay line, then TAPS multiply-
//   accumulate steps are issued to the PE with pe_Yout fed back as pe_Yin.
//   The final accumulator value is returned on a valid/ready port.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     coef_we/addr/wdata  coefficient write (accepted in IDLE only)
//     coef_err            1-cycle pulse: write rejected (busy or bad address)
//     flush               zero the delay line (IDLE only)
//     io (slave)          x_* sample stream in, y_* result stream out
//     busy                high whenever the sequencer is not IDLE
//     pe_Cin/Xin/Yin      operands to the PE (zero outside MAC)
//     pe_Yout             PE accumulator output
// -----------------------------------------------------------------------------
module fir_pe_fold_ctrl #(
    parameter  int TAPS   = 8,
    parameter  int CW     = 8,
    parameter  int XW     = 8,
    parameter  int YW     = 16,
    parameter  int PE_LAT = 1,
    localparam int AW     = (TAPS > 1) ? $clog2(TAPS) : 1,
    localparam int LW     = (PE_LAT > 1) ? $clog2(PE_LAT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    coef_we,
    input  logic [AW-1:0]           coef_addr,
    input  logic [CW-1:0]           coef_wdata,
    output logic                    coef_err,

    input  logic                    flush,

    fir_pe_fold_ctrl_if.slave       io,

    output logic                    busy,

    output logic [CW-1:0]           pe_Cin,
    output logic [XW-1:0]           pe_Xin,
    output logic [YW-1:0]           pe_Yin,
    input  logic [YW-1:0]           pe_Yout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   tap;
    logic [LW-1:0]   lat;
    logic [CW-1:0]   coef [TAPS];
    logic [XW-1:0]   dly  [TAPS];
    logic [YW-1:0]   y_data_q;

    logic            tap_last;
    logic            lat_last;
    logic            accept;
    logic            addr_ok;
    logic            coef_wr;

    assign tap_last = (tap == AW'(TAPS - 1));
    assign lat_last = (lat == LW'(PE_LAT - 1));
    assign accept   = io.x_valid && io.x_ready;
    assign addr_ok  = (int'(coef_addr) < TAPS);
    assign coef_wr  = coef_we && (state == S_IDLE) && addr_ok;

    // x_ready is held low while reset is asserted, not only after it.
    assign io.x_ready = rst_n && (state == S_IDLE);
    assign io.y_valid = (state == S_OUT);
    assign io.y_data  = y_data_q;
    assign busy       = (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept)               state_nxt = S_MAC;
            S_MAC:   if (lat_last && tap_last) state_nxt = S_DRAIN;
            S_DRAIN: if (lat_last)             state_nxt = S_OUT;
            S_OUT:   if (io.y_ready)           state_nxt = S_IDLE;
            default:                           state_nxt = S_IDLE;
        endcase
    end

    // PE operands: only MAC drives anything. Tap 0 starts the accumulation
    // from zero; later taps chain the PE's own output back in.
    always_comb begin
        pe_Cin = '0;
        pe_Xin = '0;
        pe_Yin = '0;
        if (state == S_MAC) begin
            pe_Cin = coef[tap];
            pe_Xin = dly[tap];
            pe_Yin = (tap == '0) ? '0 : pe_Yout;
        end
    end

    // Tap counter and per-tap latency counter. Both return to zero on every
    // FSM exit from MAC/DRAIN, so tap never passes TAPS-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap <= '0;
            lat <= '0;
        end else begin
            unique case (state)
                S_MAC: begin
                    if (lat_last) begin
                        lat <= '0;
                        tap <= tap_last ? '0 : tap + AW'(1);
                    end else begin
                        lat <= lat + LW'(1);
                    end
                end
                S_DRAIN: lat <= lat_last ? '0 : lat + LW'(1);
                default: begin
                    tap <= '0;
                    lat <= '0;
                end
            endcase
        end
    end

    // NOTE: the coefficient file and delay line are flop arrays with an
    // async reset because their post-reset contents must read as zero; a
    // RAM-style array without reset would not meet that.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) coef[i] <= '0;
        end else if (coef_wr) begin
            coef[coef_addr] <= coef_wdata;
        end
    end

    // Delay line. Flush and accept in the same cycle behave as "flush, then
    // shift": the new sample lands in d[0] and every older tap becomes 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) dly[i] <= '0;
        end else if (state == S_IDLE) begin
            if (accept) begin
                dly[0] <= io.x_data;
                for (int i = 1; i < TAPS; i++) dly[i] <= flush ? '0 : dly[i-1];
            end else if (flush) begin
                for (int i = 0; i < TAPS; i++) dly[i] <= '0;
            end
        end
    end

    // Result capture on the last DRAIN cycle, held stable through OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          y_data_q <= '0;
        else if (state == S_DRAIN && lat_last) y_data_q <= pe_Yout;
    end

    // Rejected writes report one cycle after the offending strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) coef_err <= 1'b0;
        else        coef_err <= coef_we && ((state != S_IDLE) || !addr_ok);
    end

endmodule

// File: tb/tb_fir_pe_fold_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fir_pe_fold_ctrl
//   Directed bench for the folded FIR sequencer with a behavioural fir_pe
//   (Yout <= Yin + Cin*Xin, one register stage). Inputs change and outputs
//   are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fir_pe_fold_ctrl;

    localparam int TAPS = 8;
    localparam int CW   = 8;
    localparam int XW   = 8;
    localparam int YW   = 16;
    localparam int AW   = 3;

    logic          clk;
    logic          rst_n;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_wdata;
    logic          coef_err;
    logic          flush;
    logic          busy;
    logic [CW-1:0] pe_Cin;
    logic [XW-1:0] pe_Xin;
    logic [YW-1:0] pe_Yin;
    logic [YW-1:0] pe_Yout;

    int n_tests = 0;
    int n_fail  = 0;

    fir_pe_fold_ctrl_if #(.XW(XW), .YW(YW)) bus ();

    fir_pe_fold_ctrl #(
        .TAPS(TAPS), .CW(CW), .XW(XW), .YW(YW), .PE_LAT(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_err   (coef_err),
        .flush      (flush),
        .io         (bus),
        .busy       (busy),
        .pe_Cin     (pe_Cin),
        .pe_Xin     (pe_Xin),
        .pe_Yin     (pe_Yin),
        .pe_Yout    (pe_Yout)
    );

    // Behavioural processing element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pe_Yout <= '0;
        else        pe_Yout <= pe_Yin + (pe_Cin * pe_Xin);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_coef(input int a, input int v);
        coef_addr  = AW'(a);
        coef_wdata = CW'(v);
        coef_we    = 1'b1;
        @(negedge clk);
        coef_we    = 1'b0;
    endtask

    task automatic load_coefs();
        for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
        check("coef_err_idle", coef_err, 1'b0);
    endtask

    // Offer one sample at a falling edge; returns at the falling edge after
    // the accept edge (first MAC cycle).
    task automatic start_sample(input int x);
        bus.x_valid = 1'b1;
        bus.x_data  = XW'(x);
        check("x_ready_idle", bus.x_ready, 1'b1);
        @(negedge clk);
        bus.x_valid = 1'b0;
    endtask

    // lat0 = rising edges already seen since (and including) the accept edge.
    task automatic wait_result(input int exp, input string tag, input int lat0,
                               input int hold, output int lat);
        logic [YW-1:0] held;
        lat = lat0;
        while (!bus.y_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_valid"}, bus.y_valid, 1'b1);
        check(tag, bus.y_data, exp);
        held = bus.y_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", bus.y_valid, 1'b1);
            check("hold_data",  bus.y_data, held);
            check("hold_xready", bus.x_ready, 1'b0);
            check("hold_pe", {pe_Cin, pe_Xin, pe_Yin}, 32'd0);
        end
        bus.y_ready = 1'b1;
        @(negedge clk);
        bus.y_ready = 1'b0;
    endtask

    task automatic run(input int x, input int exp, input string tag);
        int lat;
        start_sample(x);
        wait_result(exp, tag, 1, 0, lat);
    endtask

    int ramp [10] = '{1, 3, 6, 10, 15, 21, 28, 36, 36, 36};

    initial begin
        int lat;
        rst_n       = 1'b1;
        coef_we     = 1'b0;
        coef_addr   = '0;
        coef_wdata  = '0;
        flush       = 1'b0;
        bus.x_valid = 1'b0;
        bus.x_data  = '0;
        bus.y_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;

        // Reset state
        check("rst_x_ready",  bus.x_ready, 1'b0);
        check("rst_y_valid",  bus.y_valid, 1'b0);
        check("rst_y_data",   bus.y_data, 0);
        check("rst_busy",     busy, 1'b0);
        check("rst_coef_err", coef_err, 1'b0);
        check("rst_pe", {pe_Cin, pe_Xin, pe_Yin}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_x_ready", bus.x_ready, 1'b1);
        @(negedge clk);

        // 1: impulse response
        load_coefs();
        for (int i = 0; i < TAPS; i++) run((i == 0) ? 1 : 0, i + 1, "impulse");

        // 2: step response
        for (int i = 0; i < 10; i++) run(1, ramp[i], "ramp");

        // 3: back-pressure for 20 cycles in OUT
        start_sample(1);
        wait_result(36, "stall", 1, 20, lat);

        // 4: coefficient write during MAC is dropped and flagged
        start_sample(1);
        coef_addr  = 3'd0;
        coef_wdata = 8'd100;
        coef_we    = 1'b1;
        @(negedge clk);
        coef_we    = 1'b0;
        check("busy_mac", busy, 1'b1);
        check("coef_err_pulse", coef_err, 1'b1);
        @(negedge clk);
        check("coef_err_clear", coef_err, 1'b0);
        wait_result(36, "drop_cur", 3, 0, lat);
        run(1, 36, "drop_next");

        // 5: reset during MAC tap 4
        start_sample(1);
        repeat (4) @(negedge clk);
        check("tap4_cin", pe_Cin, 5);
        check("tap4_xin", pe_Xin, 1);
        check("tap4_yin", pe_Yin, 10);
        rst_n = 1'b0;
        #1;
        check("abort_x_ready", bus.x_ready, 1'b0);
        check("abort_y_valid", bus.y_valid, 1'b0);
        check("abort_y_data",  bus.y_data, 0);
        check("abort_busy",    busy, 1'b0);
        check("abort_pe", {pe_Cin, pe_Xin, pe_Yin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_coefs();
        for (int i = 0; i < TAPS; i++) run((i == 0) ? 1 : 0, i + 1, "impulse_rst");

        // 6: flush in IDLE, then latency check
        run(1, 1, "pre_flush0");
        run(1, 3, "pre_flush1");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        start_sample(2);
        wait_result(2, "post_flush", 1, 0, lat);
        check("latency", lat, 10);

        // 7: flush + coef write + accept in one IDLE cycle -> d=[3,0..], c0=5
        bus.x_valid = 1'b1;
        bus.x_data  = 8'd3;
        flush       = 1'b1;
        coef_addr   = 3'd0;
        coef_wdata  = 8'd5;
        coef_we     = 1'b1;
        @(negedge clk);
        bus.x_valid = 1'b0;
        flush       = 1'b0;
        coef_we     = 1'b0;
        check("same_cycle_err", coef_err, 1'b0);
        wait_result(15, "same_cycle", 1, 0, lat);

        // 8: flush during MAC is ignored -> d=[1,3,0..], y=5*1+2*3
        start_sample(1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_result(11, "flush_busy", 2, 0, lat);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
